sipo_frame_rx: RTL and testbench

- Serial-to-parallel frame receiver: the stage directly downstream of the team's parallel-in/serial-out shifter.
- Consumes a framed serial stream, MSB first, qualified by a bit strobe. Each frame is start, data, optional parity, stop.
- Checks parity and stop bits and presents each good word on a valid/ready output with one-word holding.
- Counts errors with a saturating counter.

---
 rtl/sipo_frame_rx.sv | 146 ++++++++++++++
 tb/tb_sipo_frame_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: receives framed serial words (start, data MSB first, optional
// even parity, stop), checks the frame, and holds one good word on a
// valid/ready output. Parity errors, frame errors and overruns are pulsed and
// counted in a saturating counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a 1 start bit on a strobe
// S_DATA   | shifting in DATA_W data bits, first bit ends up in the MSB
// S_PARITY | capturing the even-parity bit (only when PARITY_EN=1)
// S_STOP   | sampling the stop bit and judging the frame
module sipo_frame_rx #(
  parameter int DATA_W    = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                sample_en,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_par;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_parity_err;
  logic                r_frame_err;
  logic                r_overrun;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic w_last_bit;
  logic w_stop_eval;
  logic w_par_bad;
  logic w_fe;
  logic w_pe;
  logic w_good;
  logic w_load;
  logic w_ovr;
  logic w_any_err;

  assign w_last_bit  = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_stop_eval = (r_state == S_STOP) && sample_en;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_bad   = PARITY_EN && ((^r_sr) ^ r_par);
  // A high stop bit outranks a parity mismatch, so each frame reports one class.
  assign w_fe        = w_stop_eval && serial_in;
  assign w_pe        = w_stop_eval && !serial_in && w_par_bad;
  assign w_good      = w_stop_eval && !serial_in && !w_par_bad;
  // A word being consumed this cycle frees the holding register for the new one.
  assign w_load      = w_good && (!r_out_valid || out_ready);
  assign w_ovr       = w_good && !w_load;
  assign w_any_err   = w_fe || w_pe || w_ovr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; every transition is gated by the bit strobe.
  always_comb begin
    w_state_nxt = r_state;
    if (sample_en) begin
      case (r_state)
        S_IDLE:   if (serial_in) w_state_nxt = S_DATA;
        S_DATA:   if (w_last_bit) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (sample_en) begin
      case (r_state)
        S_IDLE: if (serial_in) r_cnt <= '0;
        S_DATA: begin
          r_sr  <= {r_sr[DATA_W-2:0], serial_in};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_PARITY: r_par <= serial_in;
        default: ;
      endcase
    end
  end

  // Holding register, valid flag, error pulses and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_parity_err <= w_pe;
      r_frame_err  <= w_fe;
      r_overrun    <= w_ovr;
      if (w_load) begin
        r_out_data  <= r_sr;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_any_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_IDLE);
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx: directed frames; expected words and error
// events are queued by the stimulus and checked by an independent monitor.
module tb_sipo_frame_rx;

  localparam int DW = 4;
  localparam int EW = 2;

  localparam logic [2:0] EV_PE  = 3'b100;
  localparam logic [2:0] EV_FE  = 3'b010;
  localparam logic [2:0] EV_OVR = 3'b001;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          sample_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic [EW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_words[$];
  logic [2:0]    exp_events[$];

  sipo_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b1), .ERRCNT_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .sample_en  (sample_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted words and error pulses are matched against the queues.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        if (exp_words.size() == 0) chk("unexpected_word", {28'd0, out_data}, 32'hFFFF_FFFF);
        else chk("word", {28'd0, out_data}, {28'd0, exp_words.pop_front()});
      end
      if (parity_err || frame_err || overrun) begin
        if (exp_events.size() == 0)
          chk("unexpected_event", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        else
          chk("event", {29'd0, parity_err, frame_err, overrun}, {29'd0, exp_events.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int stride);
    serial_in = b;
    sample_en = 1'b1;
    tick();
    serial_in = 1'b0;
    sample_en = 1'b0;
    repeat (stride - 1) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int stride);
    send_bit(1'b1, stride);
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i], stride);
    send_bit(p, stride);
    send_bit(s, stride);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    serial_in = 1'b0;
    sample_en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset_state", {busy, out_valid, parity_err, frame_err, overrun, err_cnt, out_data},
        32'd0);
    rst = 1'b0;
    tick();

    // Good frame 4'hB, parity 1.
    exp_words.push_back(4'hB);
    send_frame(4'hB, 1'b1, 1'b0, 1);
    chk("good_valid", {31'd0, out_valid}, 32'd1);
    chk("good_data", {28'd0, out_data}, 32'hB);
    chk("good_errcnt", {30'd0, err_cnt}, 32'd0);
    repeat (2) tick();

    // Parity error, then good 4'h6.
    do_reset();
    exp_events.push_back(EV_PE);
    send_frame(4'hB, 1'b0, 1'b0, 1);
    chk("pe_valid", {31'd0, out_valid}, 32'd0);
    chk("pe_errcnt", {30'd0, err_cnt}, 32'd1);
    exp_words.push_back(4'h6);
    send_frame(4'h6, 1'b0, 1'b0, 1);
    chk("pe_next_data", {28'd0, out_data}, 32'h6);
    repeat (2) tick();

    // Frame error: high stop bit is not a new start.
    do_reset();
    exp_events.push_back(EV_FE);
    send_frame(4'hB, 1'b1, 1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b0, 1);
    chk("fe_busy", {31'd0, busy}, 32'd0);
    chk("fe_errcnt", {30'd0, err_cnt}, 32'd1);
    chk("fe_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure and overrun.
    do_reset();
    out_ready = 1'b0;
    exp_words.push_back(4'hB);
    send_frame(4'hB, 1'b1, 1'b0, 1);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    exp_events.push_back(EV_OVR);
    send_frame(4'h3, 1'b0, 1'b0, 1);
    chk("ovr_data", {28'd0, out_data}, 32'hB);
    chk("ovr_errcnt", {30'd0, err_cnt}, 32'd1);
    tick();
    chk("ovr_hold", {27'd0, out_valid, out_data}, 32'h1B);
    out_ready = 1'b1;
    tick();
    chk("bp_release", {31'd0, out_valid}, 32'd0);

    // Consume and deliver in the same cycle.
    do_reset();
    out_ready = 1'b0;
    exp_words.push_back(4'hB);
    send_frame(4'hB, 1'b1, 1'b0, 1);
    exp_words.push_back(4'h5);
    send_bit(1'b1, 1);
    for (int i = DW - 1; i >= 0; i--) send_bit(4'(4'h5 >> i) & 4'h1 ? 1'b1 : 1'b0, 1);
    send_bit(1'b0, 1);
    out_ready = 1'b1;
    send_bit(1'b0, 1);
    chk("simul_valid", {31'd0, out_valid}, 32'd1);
    chk("simul_data", {28'd0, out_data}, 32'h5);
    chk("simul_errcnt", {30'd0, err_cnt}, 32'd0);
    repeat (2) tick();

    // Sparse strobe, reset mid-DATA, then frame 4'hA.
    send_bit(1'b1, 3);
    send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    chk("sparse_busy", {31'd0, busy}, 32'd1);
    do_reset();
    chk("midreset_state", {busy, out_valid, parity_err, frame_err, overrun, err_cnt, out_data},
        32'd0);
    exp_words.push_back(4'hA);
    send_frame(4'hA, 1'b0, 1'b0, 3);
    repeat (3) tick();

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_events.push_back(EV_FE);
      send_frame(4'h0, 1'b0, 1'b1, 1);
      chk("sat_errcnt", {30'd0, err_cnt}, (i < 3) ? i + 1 : 3);
    end
    repeat (3) tick();

    chk("words_drained", exp_words.size(), 32'd0);
    chk("events_drained", exp_events.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
